// File: rtl/multi_pattern_comparator_pkg.sv
// -----------------------------------------------------------------------------
// mpc_pkg
// Shared types, default widths and the window extraction helper for the
// multi-pattern byte-stream comparator.
//   byte_t     : one stream byte
//   DEF_*      : default parameter values for the comparator
//   MAX_*      : upper bounds that size the window_at() argument vectors
//   window_at  : returns the PATTERN_BYTES-long window of the stream
//                {hist, word} that ends in byte lane k of the word
// -----------------------------------------------------------------------------
package mpc_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEF_DATA_BYTES    = 4;
    localparam int DEF_PATTERN_BYTES = 4;
    localparam int DEF_NUM_PATTERNS  = 4;
    localparam int DEF_CNT_W         = 16;

    localparam int MAX_PATTERN_BYTES = 16;
    localparam int MAX_HIST_BYTES    = MAX_PATTERN_BYTES - 1;
    localparam int MAX_DATA_BYTES    = 16;

    // hist and word are right-justified in their max-width vectors. Stream byte
    // j counts from the oldest history byte; the window ending at word lane k
    // starts at stream byte k (history is exactly pat_bytes-1 bytes long).
    // The result is right-justified with the first window byte as its MSB
    // byte; unused upper bytes are zero.
    function automatic logic [8*MAX_PATTERN_BYTES-1:0] window_at(
        input logic [8*MAX_HIST_BYTES-1:0] hist,
        input int                          hist_bytes,
        input logic [8*MAX_DATA_BYTES-1:0] word,
        input int                          word_bytes,
        input int                          pat_bytes,
        input int                          k
    );
        logic [8*MAX_PATTERN_BYTES-1:0] win;
        byte_t                          b;
        int                             j;
        win = '0;
        for (int i = 0; i < MAX_PATTERN_BYTES; i++) begin
            if (i < pat_bytes) begin
                j = k + i;
                if (j < hist_bytes)
                    b = hist[8*(hist_bytes-1-j) +: 8];
                else
                    b = word[8*(word_bytes-1-(j-hist_bytes)) +: 8];
                win[8*(pat_bytes-1-i) +: 8] = b;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/multi_pattern_comparator_pattern_table.sv
// -----------------------------------------------------------------------------
// pattern_table
// NUM_PATTERNS entries of (pattern, enable), written one entry per cycle.
// Reads are combinational from the registers, so a write is visible to words
// arriving on the cycle after wr_en.
//   clk, n_rst  : clock, asynchronous active-low reset (clears all entries)
//   wr_en       : write strobe
//   wr_addr     : entry to write
//   wr_data     : pattern, MSB byte = first byte on the wire
//   wr_enable   : enable bit stored with the entry
//   pat, pat_en : current table contents
// -----------------------------------------------------------------------------
module pattern_table
    import mpc_pkg::*;
#(
    parameter int PATTERN_BYTES = DEF_PATTERN_BYTES,
    parameter int NUM_PATTERNS  = DEF_NUM_PATTERNS,
    parameter int IDX_W         = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
)(
    input  logic                                        clk,
    input  logic                                        n_rst,
    input  logic                                        wr_en,
    input  logic [IDX_W-1:0]                            wr_addr,
    input  logic [8*PATTERN_BYTES-1:0]                  wr_data,
    input  logic                                        wr_enable,
    output logic [NUM_PATTERNS-1:0][8*PATTERN_BYTES-1:0] pat,
    output logic [NUM_PATTERNS-1:0]                     pat_en
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pat    <= '0;
            pat_en <= '0;
        end else if (wr_en && (int'(wr_addr) < NUM_PATTERNS)) begin
            pat[wr_addr]    <= wr_data;
            pat_en[wr_addr] <= wr_enable;
        end
    end

endmodule

// File: rtl/multi_pattern_comparator.sv
// -----------------------------------------------------------------------------
// multi_pattern_comparator
// Scans a byte stream (DATA_BYTES per word, MSB byte first on the wire) for
// any of NUM_PATTERNS programmable patterns at every byte alignment,
// including across word boundaries, and forwards the word one cycle later
// together with its match result.
//   clk, n_rst        : clock, asynchronous active-low reset
//   clear             : frame boundary; flush history and sticky state
//   data_valid/data_in: input word stream
//   pat_wr_*          : pattern table write port
//   data_out(_valid)  : input delayed one cycle
//   match_pulse/vec   : per-cycle hit summary / per-entry hits
//   match_index       : lowest hitting entry
//   match_offset      : lane of the pattern's last byte for match_index
//   match             : sticky hit flag since clear
//   match_count       : saturating count of hit cycles since clear
// -----------------------------------------------------------------------------
module multi_pattern_comparator
    import mpc_pkg::*;
#(
    parameter int DATA_BYTES    = DEF_DATA_BYTES,
    parameter int PATTERN_BYTES = DEF_PATTERN_BYTES,
    parameter int NUM_PATTERNS  = DEF_NUM_PATTERNS,
    parameter int IDX_W         = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    parameter int CNT_W         = DEF_CNT_W,
    localparam int OFF_W        = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
)(
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic                       data_valid,
    input  logic [8*DATA_BYTES-1:0]    data_in,
    input  logic                       pat_wr_en,
    input  logic [IDX_W-1:0]           pat_wr_addr,
    input  logic [8*PATTERN_BYTES-1:0] pat_wr_data,
    input  logic                       pat_wr_enable,
    output logic [8*DATA_BYTES-1:0]    data_out,
    output logic                       data_out_valid,
    output logic                       match_pulse,
    output logic [NUM_PATTERNS-1:0]    match_vec,
    output logic [IDX_W-1:0]           match_index,
    output logic [OFF_W-1:0]           match_offset,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count
);

    localparam int HIST_BYTES = PATTERN_BYTES - 1;
    // Keep at least one byte of storage so a 1-byte pattern still elaborates.
    localparam int HIST_REG_BYTES = (HIST_BYTES > 0) ? HIST_BYTES : 1;
    localparam int SEEN_W = $clog2(PATTERN_BYTES + 1);

    logic [NUM_PATTERNS-1:0][8*PATTERN_BYTES-1:0] pat_tbl;
    logic [NUM_PATTERNS-1:0]                      pat_en;

    logic [8*HIST_REG_BYTES-1:0] hist_p0;
    logic [SEEN_W-1:0]           seen_p0;

    logic [8*HIST_REG_BYTES-1:0]    hist_cur;
    logic [SEEN_W-1:0]              seen_cur;
    logic [8*HIST_REG_BYTES-1:0]    hist_nxt;
    logic [SEEN_W-1:0]              seen_nxt;
    logic [8*MAX_HIST_BYTES-1:0]    hist_ext;
    logic [8*MAX_DATA_BYTES-1:0]    word_ext;
    logic [8*MAX_PATTERN_BYTES-1:0] win     [DATA_BYTES];
    logic [8*MAX_PATTERN_BYTES-1:0] pat_ext [NUM_PATTERNS];
    logic [OFF_W-1:0]               ent_off [NUM_PATTERNS];
    logic [DATA_BYTES-1:0]          lane_ok;
    logic [NUM_PATTERNS-1:0]        hit_vec;
    logic [IDX_W-1:0]               hit_idx;
    logic [OFF_W-1:0]               hit_off;
    logic                           any_hit;
    int                             seen_sum;

    pattern_table #(
        .PATTERN_BYTES (PATTERN_BYTES),
        .NUM_PATTERNS  (NUM_PATTERNS),
        .IDX_W         (IDX_W)
    ) u_table (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_en     (pat_wr_en),
        .wr_addr   (pat_wr_addr),
        .wr_data   (pat_wr_data),
        .wr_enable (pat_wr_enable),
        .pat       (pat_tbl),
        .pat_en    (pat_en)
    );

    // clear flushes the frame before the same-cycle word is looked at, so
    // that word is compared as the first word of a new frame.
    always_comb begin
        hist_cur = clear ? '0 : hist_p0;
        seen_cur = clear ? '0 : seen_p0;

        hist_ext = '0;
        hist_ext[8*HIST_REG_BYTES-1:0] = hist_cur;
        word_ext = '0;
        word_ext[8*DATA_BYTES-1:0] = data_in;

        // A lane is legal only once the window ending there lies entirely in
        // bytes received this frame, never in flushed zero history.
        for (int k = 0; k < DATA_BYTES; k++) begin
            win[k] = window_at(hist_ext, HIST_BYTES, word_ext, DATA_BYTES,
                               PATTERN_BYTES, k);
            lane_ok[k] = (int'(seen_cur) + k + 1) >= PATTERN_BYTES;
        end

        // Scan lanes high to low so the lowest hitting lane is kept.
        for (int e = 0; e < NUM_PATTERNS; e++) begin
            pat_ext[e] = '0;
            pat_ext[e][8*PATTERN_BYTES-1:0] = pat_tbl[e];
            ent_off[e] = '0;
            hit_vec[e] = 1'b0;
            for (int k = DATA_BYTES - 1; k >= 0; k--) begin
                if (data_valid && pat_en[e] && lane_ok[k] && (win[k] == pat_ext[e])) begin
                    hit_vec[e] = 1'b1;
                    ent_off[e] = OFF_W'(k);
                end
            end
        end

        hit_idx = '0;
        hit_off = '0;
        for (int e = NUM_PATTERNS - 1; e >= 0; e--) begin
            if (hit_vec[e]) begin
                hit_idx = IDX_W'(e);
                hit_off = ent_off[e];
            end
        end
        any_hit = |hit_vec;

        // New history is the youngest HIST_REG_BYTES bytes of {hist, word}.
        for (int b = 0; b < HIST_REG_BYTES; b++) begin
            if (b < DATA_BYTES)
                hist_nxt[8*b +: 8] = data_in[8*b +: 8];
            else
                hist_nxt[8*b +: 8] = hist_cur[8*(b-DATA_BYTES) +: 8];
        end

        seen_sum = int'(seen_cur) + DATA_BYTES;
        seen_nxt = (seen_sum >= PATTERN_BYTES) ? SEEN_W'(PATTERN_BYTES) : SEEN_W'(seen_sum);
    end

    // ---- stage p0: stream history and byte count -------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_p0 <= '0;
            seen_p0 <= '0;
        end else if (data_valid) begin
            hist_p0 <= hist_nxt;
            seen_p0 <= seen_nxt;
        end else if (clear) begin
            hist_p0 <= '0;
            seen_p0 <= '0;
        end
    end

    // ---- stage p1: registered outputs aligned with data_out --------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            match_pulse    <= 1'b0;
            match_vec      <= '0;
            match_index    <= '0;
            match_offset   <= '0;
            match          <= 1'b0;
            match_count    <= '0;
        end else begin
            data_out       <= data_in;
            data_out_valid <= data_valid;
            match_pulse    <= any_hit;
            match_vec      <= hit_vec;
            match_index    <= hit_idx;
            match_offset   <= hit_off;
            if (clear) begin
                match       <= any_hit;
                match_count <= any_hit ? CNT_W'(1) : '0;
            end else if (any_hit) begin
                match <= 1'b1;
                if (match_count != '1)
                    match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_pattern_comparator.sv
// -----------------------------------------------------------------------------
// tb_multi_pattern_comparator
// Directed and randomized stimulus against a byte-queue reference model of the
// comparator (default parameters: 4-byte words, 4-byte patterns, 4 entries).
// -----------------------------------------------------------------------------
module tb_multi_pattern_comparator;

    localparam int DB = 4;
    localparam int PB = 4;
    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        data_valid;
    logic [31:0] data_in;
    logic        pat_wr_en;
    logic [1:0]  pat_wr_addr;
    logic [31:0] pat_wr_data;
    logic        pat_wr_enable;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        match_pulse;
    logic [3:0]  match_vec;
    logic [1:0]  match_index;
    logic [1:0]  match_offset;
    logic        match;
    logic [15:0] match_count;

    multi_pattern_comparator dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear          (clear),
        .data_valid     (data_valid),
        .data_in        (data_in),
        .pat_wr_en      (pat_wr_en),
        .pat_wr_addr    (pat_wr_addr),
        .pat_wr_data    (pat_wr_data),
        .pat_wr_enable  (pat_wr_enable),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .match_pulse    (match_pulse),
        .match_vec      (match_vec),
        .match_index    (match_index),
        .match_offset   (match_offset),
        .match          (match),
        .match_count    (match_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    // Reference model: the frame as a plain byte queue plus the pattern table.
    logic [31:0] m_pat [NP];
    bit          m_en  [NP];
    logic [7:0]  frame [$];
    bit          m_match;
    int          m_count;

    logic [31:0] e_dout;
    bit          e_dv;
    bit          e_pulse;
    logic [3:0]  e_vec;
    int          e_idx;
    int          e_off;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < NP; e++) begin
            m_pat[e] = '0;
            m_en[e]  = 1'b0;
        end
        frame.delete();
        m_match = 1'b0;
        m_count = 0;
    endtask

    task automatic idle_inputs();
        clear         = 1'b0;
        data_valid    = 1'b0;
        data_in       = '0;
        pat_wr_en     = 1'b0;
        pat_wr_addr   = '0;
        pat_wr_data   = '0;
        pat_wr_enable = 1'b0;
    endtask

    // One clock cycle: drive, predict, then check all outputs after the edge.
    task automatic cyc(input bit v, input logic [31:0] d, input bit clr,
                       input bit we, input int wa, input logic [31:0] wd, input bit wen);
        int          n;
        int          off_of [NP];
        logic [31:0] w;
        @(negedge clk);
        step++;
        data_valid    = v;
        data_in       = d;
        clear         = clr;
        pat_wr_en     = we;
        pat_wr_addr   = wa[1:0];
        pat_wr_data   = wd;
        pat_wr_enable = wen;

        if (clr) begin
            frame.delete();
            m_match = 1'b0;
            m_count = 0;
        end
        e_vec = '0;
        e_idx = 0;
        e_off = 0;
        for (int e = 0; e < NP; e++) off_of[e] = 0;
        if (v) begin
            for (int b = 0; b < DB; b++) frame.push_back(d[8*(DB-1-b) +: 8]);
            n = frame.size();
            for (int k = 0; k < DB; k++) begin
                int last;
                last = n - DB + k;
                if (last - PB + 1 >= 0) begin
                    w = {frame[last-3], frame[last-2], frame[last-1], frame[last]};
                    for (int e = 0; e < NP; e++) begin
                        if (m_en[e] && m_pat[e] == w && !e_vec[e]) begin
                            e_vec[e]  = 1'b1;
                            off_of[e] = k;
                        end
                    end
                end
            end
            while (frame.size() > 32) void'(frame.pop_front());
        end
        e_pulse = |e_vec;
        for (int e = NP - 1; e >= 0; e--) begin
            if (e_vec[e]) begin
                e_idx = e;
                e_off = off_of[e];
            end
        end
        if (e_pulse) begin
            m_match = 1'b1;
            if (m_count < 65535) m_count++;
        end
        e_dout = d;
        e_dv   = v;
        if (we) begin
            m_pat[wa] = wd;
            m_en[wa]  = wen;
        end

        @(posedge clk);
        #1;
        chk("data_out", data_out, e_dout);
        chk("data_out_valid", 32'(data_out_valid), 32'(e_dv));
        chk("match_pulse", 32'(match_pulse), 32'(e_pulse));
        chk("match_vec", 32'(match_vec), 32'(e_vec));
        chk("match", 32'(match), 32'(m_match));
        chk("match_count", 32'(match_count), 32'(m_count));
        if (e_pulse) begin
            chk("match_index", 32'(match_index), 32'(e_idx));
            chk("match_offset", 32'(match_offset), 32'(e_off));
        end
    endtask

    task automatic word(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [31:0] p, input bit en);
        cyc(1'b0, '0, 1'b0, 1'b1, a, p, en);
    endtask

    task automatic clr_cycle();
        cyc(1'b0, '0, 1'b1, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"}, data_out, 32'h0);
        chk({tag, "_dvalid"}, 32'(data_out_valid), 32'h0);
        chk({tag, "_pulse"}, 32'(match_pulse), 32'h0);
        chk({tag, "_vec"}, 32'(match_vec), 32'h0);
        chk({tag, "_index"}, 32'(match_index), 32'h0);
        chk({tag, "_offset"}, 32'(match_offset), 32'h0);
        chk({tag, "_match"}, 32'(match), 32'h0);
        chk({tag, "_count"}, 32'(match_count), 32'h0);
    endtask

    function automatic logic [7:0] rbyte();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hC0;
            2:       return 8'hA8;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [31:0] rword();
        return {rbyte(), rbyte(), rbyte(), rbyte()};
    endfunction

    initial begin
        idle_inputs();
        model_reset();
        n_rst = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Basic aligned hit.
        wr(0, 32'hC0A80101, 1'b1);
        word(32'hC0A80101);
        chk("basic_offset", 32'(match_offset), 32'd3);
        chk("basic_count", 32'(match_count), 32'd1);

        // Cross-boundary alignments.
        clr_cycle();
        word(32'h0000C0A8);
        chk("split1_first_nopulse", 32'(match_pulse), 32'd0);
        word(32'h0101FFFF);
        chk("split1_offset", 32'(match_offset), 32'd1);
        word(32'h000000C0);
        word(32'hA80101FF);
        chk("split2_offset", 32'(match_offset), 32'd2);
        word(32'h00C0A801);
        word(32'h01FFFFFF);
        chk("split3_offset", 32'(match_offset), 32'd0);

        // Zero pattern must not match flushed history.
        wr(1, 32'h00000000, 1'b1);
        clr_cycle();
        word(32'h00000000);
        chk("zero_vec", 32'(match_vec), 32'b0010);
        chk("zero_offset", 32'(match_offset), 32'd3);
        clr_cycle();
        wr(1, 32'h0A000001, 1'b1);
        word(32'h0000C0A8);
        chk("guard_nopulse", 32'(match_pulse), 32'd0);

        // Multi-hit priority.
        wr(3, 32'h0A000001, 1'b1);
        clr_cycle();
        word(32'h0A000001);
        chk("multi_vec", 32'(match_vec), 32'b1010);
        chk("multi_index", 32'(match_index), 32'd1);
        chk("multi_count", 32'(match_count), 32'd1);

        // clear together with a valid word, then an idle gap mid-pattern.
        cyc(1'b1, 32'hC0A80101, 1'b1, 1'b0, 0, '0, 1'b0);
        chk("clrv_count", 32'(match_count), 32'd1);
        word(32'h0000C0A8);
        cyc(1'b0, 32'h12345678, 1'b0, 1'b0, 0, '0, 1'b0);
        chk("idle_nopulse", 32'(match_pulse), 32'd0);
        word(32'h0101FFFF);
        chk("idle_split_offset", 32'(match_offset), 32'd1);

        // Write in the same cycle as a word compares against the old entry.
        cyc(1'b1, 32'h08080808, 1'b0, 1'b1, 0, 32'h08080808, 1'b1);
        chk("samecycle_nopulse", 32'(match_pulse), 32'd0);
        word(32'h08080808);
        chk("nextcycle_pulse", 32'(match_pulse), 32'd1);

        // Asynchronous reset mid-frame.
        word(32'h0808C0A8);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        idle_inputs();
        @(negedge clk);
        n_rst = 1'b1;
        word(32'h08080808);
        chk("after_reset_nopulse", 32'(match_pulse), 32'd0);

        // Randomized traffic over a small byte alphabet to provoke hits.
        for (int e = 0; e < NP; e++) wr(e, rword(), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 600; i++) begin
            bit          v;
            bit          c;
            bit          we;
            int          wa;
            logic [31:0] wd;
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 19) == 0);
            we = ($urandom_range(0, 29) == 0);
            wa = int'($urandom_range(0, NP - 1));
            wd = rword();
            cyc(v, rword(), c, we, wa, wd, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_pattern_comparator.md
Name: multi_pattern_comparator

Overview:
Parametrised successor to the single-IP comparator. It scans a 32-bit (generally DATA_BYTES-wide) packet byte stream for any of NUM_PATTERNS programmable byte patterns (IPv4 = 4 bytes, MAC = 6 bytes), at any byte alignment and across word boundaries. It forwards the data one cycle delayed and aligned with its match result. It sits between the receive word stream and the flag/capture logic of the sniffer.

Parameters:
DATA_BYTES, 4, bytes per input word (data width = 8*DATA_BYTES)
PATTERN_BYTES, 4, pattern length in bytes, 1..16
NUM_PATTERNS, 4, number of pattern table entries
IDX_W, $clog2(NUM_PATTERNS) (min 1), width of the match index
CNT_W, 16, width of the match counter

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
clear  in  1  frame boundary: flush history, clear sticky state
data_valid  in  1  data_in holds a valid word this cycle
data_in  in  8*DATA_BYTES  stream word; [MSB byte] = first byte on the wire
pat_wr_en  in  1  write pattern table entry
pat_wr_addr  in  IDX_W  entry to write
pat_wr_data  in  8*PATTERN_BYTES  pattern; MSB byte = first byte
pat_wr_enable  in  1  enable bit stored with the entry
data_out  out  8*DATA_BYTES  data_in delayed 1 cycle
data_out_valid  out  1  data_valid delayed 1 cycle
match_pulse  out  1  one-cycle hit, aligned with data_out
match_vec  out  NUM_PATTERNS  per-entry hit this cycle (qualified by match_pulse)
match_index  out  IDX_W  lowest hitting entry
match_offset  out  $clog2(DATA_BYTES) (min 1)  byte lane in data_out holding the pattern's last byte
match  out  1  sticky; set on any hit, cleared by clear
match_count  out  CNT_W  saturating hit count since clear

Behaviour:
- Reset: all outputs 0; history 0; bytes_seen 0; all table entries 0 and disabled.
- The stream is the concatenation {history, data_in}. History holds the last PATTERN_BYTES-1 bytes received and shifts by DATA_BYTES on each valid word.
- Candidate end lane k (0 = MSB lane) in the current word is legal only if bytes_seen + k + 1 >= PATTERN_BYTES. This prevents false matches against flushed zero bytes.
- bytes_seen counts valid bytes since clear or reset and saturates at PATTERN_BYTES.
- Entry e hits when it is enabled and any legal window equals its pattern. match_offset is the lowest hitting k for match_index.
- Latency: all outputs are registered one cycle after the accepting data_valid cycle.
- match_pulse = |match_vec, and is only asserted when data_out_valid is 1. Cycles with data_valid = 0 produce match_pulse = 0 and leave history unchanged.
- Multiple entries may hit in the same cycle: match_vec shows all of them; match_index is the lowest-numbered one. match_count increments by 1 per cycle with a hit, not per entry, and saturates at all-ones.
- clear: zeroes history, bytes_seen, match and match_count on the next edge.
- clear together with data_valid: the history is flushed first, then the word is taken as the first word of a new frame. It is compared with bytes_seen = 0, and any hit it produces sets match and match_count = 1.
- data_out and data_out_valid are never gated by clear.
- Pattern write: takes effect for words arriving on the cycle after pat_wr_en. A word in the same cycle as the write compares against the old entry.
- Asynchronous reset mid-frame: everything returns to reset values immediately, and the table must be reprogrammed.

Decomposition:
- Package mpc_pkg: byte_t; default widths; the function window_at(hist, word, k) that returns PATTERN_BYTES bytes.
- Sub-module pattern_table: NUM_PATTERNS x (pattern, enable) registers with the write port. The compare and pipeline logic stays in the top module.

Test Plan:
- Reset, then entry0 = C0A80101 enabled; word C0A80101 -> next cycle: match_pulse = 1, match_index = 0, match_offset = 3, data_out = C0A80101, match = 1, match_count = 1.
- Cross-boundary alignments: words 0000C0A8 then 0101FFFF -> offset 1 on the second word. Words 000000C0 then A80101FF -> offset 2. Words 00C0A801 then 01FFFFFF -> offset 0. No pulse on any first word.
- Zero-pattern guard: entry1 = 00000000, clear, then word 00000000 -> match_pulse = 1 only for offset 3 after the first word, never from flushed history. After clear, word 0000C0A8 alone with entry0 -> no hit.
- Multi-hit and priority: entries 1 and 3 both = 0A000001; word 0A000001 -> match_vec = 1010, match_index = 1, match_count increments by 1.
- clear with data_valid on word C0A80101 -> match = 1, match_count = 1. A following idle cycle (data_valid = 0) -> match_pulse = 0, history is retained, and a split-pattern match still completes afterwards.
- Write during stream: rewrite entry0 to 08080808 on the same cycle as word 08080808 -> no hit. The same word on the next cycle -> hit.
